// File: rtl/aqp_esp_rx_fifo_if.sv
// Byte stream and status bundle between the ESP UART receive FIFO and its consumer.
// The count member exists only when ESP_RX_FIFO_COUNT_EN is defined.
interface aqp_esp_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 5
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [7:0]          rd_data;
  logic                rd_en;
  logic                empty;
  logic                full;
  logic                overflow;
  logic                ovf_clr;
  logic                flush;
`ifdef ESP_RX_FIFO_COUNT_EN
  logic [DEPTH_LOG2:0] count;
`endif

  modport slave (
    input  rx_data, rx_valid, rd_en, ovf_clr, flush,
`ifdef ESP_RX_FIFO_COUNT_EN
    output count,
`endif
    output rd_data, empty, full, overflow
  );

  modport master (
    output rx_data, rx_valid, rd_en, ovf_clr, flush,
`ifdef ESP_RX_FIFO_COUNT_EN
    input  count,
`endif
    input  rd_data, empty, full, overflow
  );
endinterface

// File: rtl/aqp_esp_rx_fifo.sv
// First-word-fall-through receive FIFO for bytes from the ESP UART, with sticky overflow.
// Define ESP_RX_FIFO_COUNT_EN to add the count output (write pointer minus read pointer).
module aqp_esp_rx_fifo #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aqp_esp_rx_fifo_if.slave     bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                ovf;
  logic                empty_c;
  logic                full_c;
  logic                do_rd;
  logic                do_wr;
  logic                drop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign do_rd = bus.rd_en & ~empty_c & ~bus.flush;
  assign do_wr = bus.rx_valid & (~full_c | do_rd) & ~bus.flush;
  assign drop  = bus.rx_valid & full_c & ~do_rd & ~bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (drop)             ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.rx_data;
  end

  assign bus.rd_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;
  assign bus.overflow = ovf;

`ifdef ESP_RX_FIFO_COUNT_EN
  assign bus.count = wr_ptr - rd_ptr;
`endif
endmodule

// File: tb/tb_aqp_esp_rx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks every pop.
module tb_aqp_esp_rx_fifo;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_q [$];

  aqp_esp_rx_fifo_if #(.DEPTH_LOG2(5)) bus ();

  aqp_esp_rx_fifo #(.DEPTH_LOG2(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_count(input string name, input int req);
`ifdef ESP_RX_FIFO_COUNT_EN
    chk(name, 32'(bus.count), 32'(req));
`endif
  endtask

  // Monitor: a pop happens on the next edge when rd_en=1, empty=0 and no flush.
  always @(negedge clk) begin
    if (reset_n && bus.rd_en && !bus.empty && !bus.flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h expected no byte at %0t", bus.rd_data, $time);
      end else begin
        chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc, input bit with_rd);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rd_en    = with_rd;
    if (acc) exp_q.push_back(b);
    cyc();
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic pop_n(input int n);
    bus.rd_en = 1'b1;
    repeat (n) cyc();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) cyc();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk_count("rst_count", 0);
    reset_n = 1'b1;
    cyc();

    // basic flow
    push(8'h41, 1, 0);
    chk("first_write_empty", 32'(bus.empty), 0);
    cyc();
    push(8'h42, 1, 0);
    cyc();
    push(8'h43, 1, 0);
    chk_count("basic_count3", 3);
    pop_n(3);
    chk("basic_empty", 32'(bus.empty), 1);
    chk_count("basic_count0", 0);

    // fill, overflow, overflow clear, full write+pop
    for (int i = 0; i < 32; i++) push(8'(i), 1, 0);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_ovf0", 32'(bus.overflow), 0);
    chk_count("fill_count32", 32);
    push(8'h20, 0, 0);
    chk("drop_ovf", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_alone", 32'(bus.overflow), 0);
    bus.ovf_clr = 1'b1;
    push(8'h77, 0, 0);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_with_drop", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_again", 32'(bus.overflow), 0);
    push(8'h55, 1, 1);
    chk("full_wr_rd_ovf", 32'(bus.overflow), 0);
    chk("full_wr_rd_full", 32'(bus.full), 1);
    chk_count("full_wr_rd_count", 32);
    pop_n(32);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_queue", 32'(exp_q.size()), 0);

    // write with read while empty: read ignored, byte appears next cycle
    push(8'h99, 1, 1);
    chk("empty_wr_rd_empty", 32'(bus.empty), 0);
    chk("empty_wr_rd_data", 32'(bus.rd_data), 32'h99);
    pop_n(1);

    // pointer wrap with interleaved traffic
    push(8'h00, 1, 0);
    for (int i = 1; i < 100; i++) begin
      push(8'(i), 1, 1);
      chk("wrap_full", 32'(bus.full), 0);
      chk("wrap_empty", 32'(bus.empty), 0);
      chk("wrap_ovf", 32'(bus.overflow), 0);
      chk_count("wrap_count", 1);
    end
    pop_n(1);
    chk("wrap_end_empty", 32'(bus.empty), 1);

    // flush with 10 bytes, concurrent write and read discarded
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i), 1, 0);
    exp_q.delete();
    bus.flush = 1'b1;
    push(8'hEE, 0, 1);
    bus.flush = 1'b0;
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_ovf", 32'(bus.overflow), 0);
    chk_count("flush_count", 0);
    push(8'hA5, 1, 0);
    chk("post_flush_data", 32'(bus.rd_data), 32'hA5);
    pop_n(1);

    // flush leaves a set overflow untouched
    for (int i = 0; i < 32; i++) push(8'h80 + 8'(i), 1, 0);
    push(8'hFF, 0, 0);
    chk("pre_flush_ovf", 32'(bus.overflow), 1);
    exp_q.delete();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flush_keeps_ovf", 32'(bus.overflow), 1);
    chk("flush_full_empty", 32'(bus.empty), 1);
    chk("flush_full_full", 32'(bus.full), 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) push(8'h10 + 8'(i), 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_empty", 32'(bus.empty), 1);
    chk("async_rst_ovf", 32'(bus.overflow), 0);
    chk("async_rst_full", 32'(bus.full), 0);
    exp_q.delete();
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    push(8'h3C, 1, 0);
    chk("post_rst_data", 32'(bus.rd_data), 32'h3C);
    chk_count("post_rst_count", 1);
    pop_n(1);
    chk("final_empty", 32'(bus.empty), 1);
    chk("final_queue", 32'(exp_q.size()), 0);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aqp_esp_rx_fifo.md
AQP_ESP_RX_FIFO -- requirements
Module: aqp_esp_rx_fifo

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, default 5, log2 of FIFO depth in bytes (depth = 32 at default).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rx_data  input  8  received byte from the ESP UART receiver.
REQ-005 SHALL have port: rx_valid  input  1  one-cycle strobe; rx_data is valid while it is high.
REQ-006 SHALL have port: rd_data  output  8  oldest stored byte (first-word-fall-through).
REQ-007 SHALL have port: rd_en  input  1  pop request for the byte on rd_data.
REQ-008 SHALL have port: empty  output  1  high when no byte is stored.
REQ-009 SHALL have port: full  output  1  high when 2^DEPTH_LOG2 bytes are stored.
REQ-010 SHALL have port: overflow  output  1  sticky flag; a received byte was dropped.
REQ-011 SHALL have port: ovf_clr  input  1  one-cycle pulse that clears overflow.
REQ-012 SHALL have port: flush  input  1  one-cycle pulse that discards all stored bytes.
REQ-013 SHALL have port (only with ESP_RX_FIFO_COUNT_EN): count  output  DEPTH_LOG2+1  number of stored bytes.

Function
REQ-014 SHALL store bytes in a circular buffer of 2^DEPTH_LOG2 x 8 bits, with separate write and read pointers of DEPTH_LOG2+1 bits that include a wrap bit.
REQ-015 SHALL derive empty and full combinationally from the pointers: empty when the pointers are equal; full when the index bits are equal and the wrap bits differ.
REQ-016 SHALL write rx_data at the write pointer and advance that pointer when rx_valid=1 and full=0.
REQ-017 SHALL drop the byte and set overflow=1 on the next edge when rx_valid=1, full=1 and the cycle does not also perform a pop.
REQ-018 SHALL accept the write without overflow when the FIFO is full and rx_valid=1 and rd_en=1 occur in the same cycle; the pop and the write both complete and full stays 1.
REQ-019 SHALL drive rd_data combinationally from the entry at the read pointer; rd_data is don't-care while empty=1.
REQ-020 SHALL advance the read pointer when rd_en=1 and empty=0, and SHALL ignore rd_en while empty=1.
REQ-021 SHALL handle rx_valid=1 with rd_en=1 while empty as follows: the read is ignored, the write is accepted, and the byte appears on rd_data with empty=0 one cycle later.
REQ-022 SHALL have a write-to-read latency of 1 cycle: empty falls on the edge that stores the first byte.
REQ-023 SHALL wrap both pointers modulo 2^(DEPTH_LOG2+1) with no special case at the buffer end.
REQ-024 SHALL clear overflow when ovf_clr=1; if a drop occurs in the same cycle, overflow SHALL end up 1 (set wins).
REQ-025 SHALL, when flush=1, set the read pointer equal to the write pointer, so empty=1 next cycle; a write or read in that same cycle is discarded and overflow is unchanged.
REQ-026 SHALL never change stored bytes except through an accepted write.

Reset
REQ-027 SHALL clear both pointers and overflow to 0 while reset_n=0, independent of clk; outputs are then empty=1, full=0, overflow=0 and count=0.
REQ-028 SHALL not reset the storage array; rd_data is undefined until the first write.
REQ-029 SHALL treat reset asserted mid-operation as an immediate discard of all contents; the first rx_valid after release is stored normally.

Configuration
REQ-030 SHALL use macro ESP_RX_FIFO_COUNT_EN: when defined, the count port exists and equals the write pointer minus the read pointer, modulo 2^(DEPTH_LOG2+1), registered-consistent with empty and full.
REQ-031 SHALL, when ESP_RX_FIFO_COUNT_EN is undefined, omit the count port and its logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover basic flow: write 0x41, 0x42, 0x43 on separate strobes, then pop 3 -> rd_data 0x41, 0x42, 0x43 in order; empty=1 after the third pop; count 3 -> 0.
REQ-033 SHALL cover fill and overflow (DEPTH_LOG2=5): 33 writes of 0x00..0x20 -> full=1 after 32, overflow=1 after the 33rd; popping 32 yields 0x00..0x1F, and 0x20 is never seen.
REQ-034 SHALL cover simultaneous write and pop when full: push 0x55 with rd_en=1 -> overflow stays 0, count stays 32, and 0x55 appears last on drain.
REQ-035 SHALL cover pointer wrap: 100 interleaved writes and pops of an incrementing byte pattern -> every byte read in order, with no spurious full, empty or overflow.
REQ-036 SHALL cover overflow clear: ovf_clr pulsed alone clears overflow; ovf_clr in the same cycle as a drop leaves overflow=1.
REQ-037 SHALL cover flush and reset: flush with 10 bytes stored -> empty=1 next cycle with overflow unchanged; reset_n pulsed low mid-stream -> empty=1 and overflow=0 immediately, without waiting for a clk edge.
